pulse_train_gen: RTL

Generates a programmable rectangular waveform: N pulses with configurable high and low widths, measured in clk cycles. It is the source-side counterpart of the team's edge-detection blocks and drives single-bit strobe and handshake lines in stimulus and control paths. The block also emits registered rise/fall strobes aligned with each wave transition. It uses a start/busy/done handshake and supports abort.

---
 rtl/pulse_train_gen_pkg.sv | 13 +
 rtl/pulse_train_gen_phase_counter.sv | 38 +++
 rtl/pulse_train_gen.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pulse_train_gen_pkg.sv
// Shared types and default widths for the pulse train generator.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam int CNT_W_DEF = 16;
  localparam int NUM_W_DEF = 8;

endpackage

// File: rtl/pulse_train_gen_phase_counter.sv
// Loadable down-counter with a registered zero flag, shared by the HIGH and LOW phases.
module phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             zero_q, zero_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
    // Flag tracks the value the counter holds next cycle, so it is ready in the phase's last cycle.
    zero_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      zero_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      zero_q  <= zero_d;
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable N-pulse rectangular waveform generator with start/busy/done handshake and abort.
// Handshake: start_i is accepted only in IDLE with stop_i low; busy_o covers the train; done_o pulses once on normal completion.
module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] high_len_i,
  input  logic [CNT_W-1:0] low_len_i,
  input  logic [NUM_W-1:0] num_pulses_i,
  output logic             wave_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] high_m1_q, high_m1_d;
  logic [CNT_W-1:0] low_m1_q, low_m1_d;
  logic [NUM_W-1:0] rem_q, rem_d;
  logic             wave_q, wave_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;
  logic             start_ok;

  assign start_ok = (state_q == IDLE) && start_i && !stop_i;

  phase_counter #(.CNT_W(CNT_W)) u_phase (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero_o   (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      high_m1_q <= '0;
      low_m1_q  <= '0;
      rem_q     <= '0;
      wave_q    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      high_m1_q <= high_m1_d;
      low_m1_q  <= low_m1_d;
      rem_q     <= rem_d;
      wave_q    <= wave_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Lengths are stored as len-1 (zero widths clamp to one cycle); rem counts pulses still to start.
  always_comb begin
    state_d      = state_q;
    high_m1_d    = high_m1_q;
    low_m1_d     = low_m1_q;
    rem_d        = rem_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      IDLE: begin
        if (start_ok && (num_pulses_i != '0)) begin
          high_m1_d    = (high_len_i == '0) ? '0 : high_len_i - CNT_W'(1);
          low_m1_d     = (low_len_i == '0) ? '0 : low_len_i - CNT_W'(1);
          rem_d        = num_pulses_i - NUM_W'(1);
          cnt_load     = 1'b1;
          cnt_load_val = high_m1_d;
          state_d      = HIGH;
        end
      end
      HIGH: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          if (rem_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_load     = 1'b1;
            cnt_load_val = low_m1_q;
            state_d      = LOW;
          end
        end
      end
      LOW: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = high_m1_q;
          rem_d        = rem_q - NUM_W'(1);
          state_d      = HIGH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wave_d = (state_d == HIGH);
    rise_d = wave_d && !wave_q;
    fall_d = !wave_d && wave_q;
    busy_d = (state_d != IDLE);
    done_d = (start_ok && (num_pulses_i == '0)) ||
             ((state_q == HIGH) && !stop_i && cnt_zero && (rem_q == '0));
  end

  assign wave_o = wave_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
